// File: rtl/sum_sq_ctrl_pkg.sv
// Shared constants and types for the sum-of-squares FIFO write controller.
package sum_sq_ctrl_pkg;

    // Avalon register addresses
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_DROPS  = 2'd3;

    // STATUS bit positions
    localparam int unsigned ST_EMPTY_BIT = 0;
    localparam int unsigned ST_FULL_BIT  = 1;
    localparam int unsigned ST_OVF_BIT   = 2;
    localparam int unsigned ST_BUSY_BIT  = 3;
    localparam int unsigned ST_LEVEL_LSB = 8;

    // CONTROL bit positions
    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_CLR_BIT = 1;

    // Downstream write sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } wr_state_e;

    // Width of a level counter able to hold 0..depth
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sum_sq_fifo_ctrl_if.sv
// Avalon-MM slave bus plus downstream FIFO write port of the controller.
interface sum_sq_fifo_ctrl_if #(
    parameter int unsigned DATA_W = 26
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              fifo_full;
    logic              fifo_wrreq;
    logic [DATA_W-1:0] fifo_data;

    // CPU / environment side
    modport master (
        output address, chipselect, write_n, writedata, fifo_full,
        input  readdata, fifo_wrreq, fifo_data
    );

    // Controller side
    modport slave (
        input  address, chipselect, write_n, writedata, fifo_full,
        output readdata, fifo_wrreq, fifo_data
    );
endinterface

// File: rtl/sum_sq_stage_queue.sv
// Circular staging queue; a push into a full queue succeeds when a pop happens in the same cycle.
module sum_sq_stage_queue #(
    parameter int unsigned DATA_W = 26,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_pop_c;
    logic              do_push_c;

    assign full      = (level == LVL_W'(DEPTH));
    assign empty     = (level == '0);
    assign head      = mem[rd_ptr];
    assign do_pop_c  = pop & ~empty & ~clear;
    assign do_push_c = push & (~full | do_pop_c) & ~clear;

    // Storage array; written only on an accepted push
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (do_push_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; clear flushes everything
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sum_sq_fifo_ctrl.sv
// Avalon-MM controller that stages CPU sum-of-squares words and drains them into the SUM_SQ FIFO.
module sum_sq_fifo_ctrl
    import sum_sq_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = 26,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    sum_sq_fifo_ctrl_if.slave  bus
);
    localparam int unsigned LVL_W    = level_w(DEPTH);
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    // Bus decode
    logic              wr_c;
    logic              push_req_c;
    logic              ctrl_wr_c;
    logic              clear_c;
    logic              launch_c;
    logic              accept_c;
    logic              drop_c;

    // Register file
    logic              enable_q;
    logic              overflow_q;
    logic [CNT_W-1:0]  drops_q;
    logic [DATA_W-1:0] last_word_q;

    // Sequencer
    wr_state_e         state_q;
    wr_state_e         state_d;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic              wrreq_q;
    logic              wrreq_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Queue status
    logic [DATA_W-1:0] q_head;
    logic              q_full;
    logic              q_empty;
    logic [LVL_W-1:0]  q_level;

    logic [31:0]       rdata_c;
    logic              unused_wdata;

    assign wr_c       = bus.chipselect & ~bus.write_n;
    assign push_req_c = wr_c & (bus.address == ADDR_DATA);
    assign ctrl_wr_c  = wr_c & (bus.address == ADDR_CTRL);
    assign clear_c    = ctrl_wr_c & bus.writedata[CTRL_CLR_BIT];

    // A launch pops the head; clear wins so a flushed word is never sent
    assign launch_c = (state_q == IDLE) & enable_q & ~q_empty & ~bus.fifo_full & ~clear_c;
    assign accept_c = push_req_c & ~clear_c & (~q_full | launch_c);
    assign drop_c   = push_req_c & ~clear_c & q_full & ~launch_c;

    // Upper writedata bits are don't-care for every register
    assign unused_wdata = ^bus.writedata;

    sum_sq_stage_queue #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (accept_c),
        .push_data (bus.writedata[DATA_W-1:0]),
        .pop       (launch_c),
        .clear     (clear_c),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .level     (q_level)
    );

    // Control, overflow, drop counter and last-accepted-word registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q    <= 1'b0;
            overflow_q  <= 1'b0;
            drops_q     <= '0;
            last_word_q <= '0;
        end else begin
            if (ctrl_wr_c) begin
                enable_q <= bus.writedata[CTRL_EN_BIT];
            end
            if (clear_c) begin
                overflow_q <= 1'b0;
                drops_q    <= '0;
            end else if (drop_c) begin
                overflow_q <= 1'b1;
                if (drops_q != '1) begin
                    drops_q <= drops_q + CNT_W'(1);
                end
            end
            if (accept_c) begin
                last_word_q <= bus.writedata[DATA_W-1:0];
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch_c) state_d = WRITE;
            WRITE:   state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     if (gap_cnt_q == GAP_W'(GAP_LAST)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer output logic: next values of the registered FIFO write port
    always_comb begin
        wrreq_d = 1'b0;
        data_d  = data_q;
        if (launch_c) begin
            wrreq_d = 1'b1;
            data_d  = q_head;
        end
    end

    // Registered downstream write port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrreq_q <= 1'b0;
            data_q  <= '0;
        end else begin
            wrreq_q <= wrreq_d;
            data_q  <= data_d;
        end
    end

    // Inter-write gap counter, runs only while in GAP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt_q <= '0;
        end else if (state_q == GAP) begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
        end else begin
            gap_cnt_q <= '0;
        end
    end

    // Zero-wait-state read mux
    always_comb begin
        rdata_c = '0;
        case (bus.address)
            ADDR_DATA: rdata_c = 32'(last_word_q);
            ADDR_STATUS: begin
                rdata_c[ST_EMPTY_BIT]           = q_empty;
                rdata_c[ST_FULL_BIT]            = q_full;
                rdata_c[ST_OVF_BIT]             = overflow_q;
                rdata_c[ST_BUSY_BIT]            = (state_q != IDLE);
                rdata_c[ST_LEVEL_LSB +: LVL_W]  = q_level;
            end
            ADDR_CTRL:  rdata_c[CTRL_EN_BIT] = enable_q;
            ADDR_DROPS: rdata_c = 32'(drops_q);
            default:    rdata_c = '0;
        endcase
    end

    assign bus.readdata   = rdata_c;
    assign bus.fifo_wrreq = wrreq_q;
    assign bus.fifo_data  = data_q;

endmodule

// File: tb/tb_sum_sq_fifo_ctrl.sv
// Scoreboard bench: one controller without gap, one with GAP_CYCLES=3, sharing clock/reset.
module tb_sum_sq_fifo_ctrl;
    import sum_sq_ctrl_pkg::*;

    localparam int unsigned DW = 26;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        cs = 1'b0;
    logic [1:0]  cs_mask = 2'b00;
    logic        write_n = 1'b1;
    logic [31:0] wdata = 32'd0;
    logic        fifo_full = 1'b0;

    always #5 clk = ~clk;

    sum_sq_fifo_ctrl_if #(.DATA_W(DW)) if0 ();
    sum_sq_fifo_ctrl_if #(.DATA_W(DW)) if3 ();

    assign if0.address    = address;
    assign if0.chipselect = cs & cs_mask[0];
    assign if0.write_n    = write_n;
    assign if0.writedata  = wdata;
    assign if0.fifo_full  = fifo_full;
    assign if3.address    = address;
    assign if3.chipselect = cs & cs_mask[1];
    assign if3.write_n    = write_n;
    assign if3.writedata  = wdata;
    assign if3.fifo_full  = fifo_full;

    sum_sq_fifo_ctrl #(.DATA_W(DW), .DEPTH(4), .GAP_CYCLES(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0.slave));
    sum_sq_fifo_ctrl #(.DATA_W(DW), .DEPTH(4), .GAP_CYCLES(3), .CNT_W(16)) dut3 (
        .clk(clk), .reset_n(reset_n), .bus(if3.slave));

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp0[$];
    logic [31:0] exp3[$];
    int          pulses0[$];
    int          pulses3[$];
    logic        full_prev = 1'b0;
    logic [31:0] e0;
    logic [31:0] e3;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) full_prev <= fifo_full;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Output monitors: pop scoreboard on every downstream write
    always @(negedge clk) begin
        if (reset_n && if0.fifo_wrreq) begin
            pulses0.push_back(cyc);
            e0 = (exp0.size() > 0) ? exp0.pop_front() : 32'hFFFF_FFFF;
            check("dut0_wr_data", 32'(if0.fifo_data), e0);
            check("dut0_wr_while_full", {31'd0, full_prev}, 32'd0);
        end
    end

    always @(negedge clk) begin
        if (reset_n && if3.fifo_wrreq) begin
            pulses3.push_back(cyc);
            e3 = (exp3.size() > 0) ? exp3.pop_front() : 32'hFFFF_FFFF;
            check("dut3_wr_data", 32'(if3.fifo_data), e3);
            check("dut3_wr_while_full", {31'd0, full_prev}, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [1:0] mask, input logic [1:0] addr, input logic [31:0] data);
        cs_mask = mask;
        address = addr;
        wdata   = data;
        write_n = 1'b0;
        cs      = 1'b1;
        step();
        cs      = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic push_word(input logic [1:0] mask, input logic [31:0] data, input bit accepted);
        if (accepted && mask[0]) exp0.push_back(data & 32'h03FF_FFFF);
        if (accepted && mask[1]) exp3.push_back(data & 32'h03FF_FFFF);
        cpu_write(mask, ADDR_DATA, data);
    endtask

    task automatic cpu_read(input int idx, input logic [1:0] addr, output logic [31:0] d);
        address = addr;
        #1;
        d = (idx == 0) ? if0.readdata : if3.readdata;
    endtask

    task automatic drain(input int idx, input int budget);
        int left;
        left = (idx == 0) ? exp0.size() : exp3.size();
        for (int i = 0; i < budget && left != 0; i++) begin
            step();
            left = (idx == 0) ? exp0.size() : exp3.size();
        end
        check("drain_timeout", 32'(left), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int n;
        int r;

        // Reset state
        repeat (3) step();
        check("rst_wrreq", {31'd0, if0.fifo_wrreq}, 32'd0);
        check("rst_data", 32'(if0.fifo_data), 32'd0);
        cpu_read(0, ADDR_STATUS, rd); check("rst_status", rd, 32'h1);
        cpu_read(0, ADDR_CTRL, rd);   check("rst_ctrl", rd, 32'h0);
        reset_n = 1'b1;
        step();
        cpu_read(0, ADDR_DROPS, rd);  check("rst_drops", rd, 32'h0);
        cpu_read(0, ADDR_DATA, rd);   check("rst_last", rd, 32'h0);
        step();

        // Back-to-back writes: latency n+2 and n+4
        cpu_write(2'b01, ADDR_CTRL, 32'h1);
        pulses0.delete();
        n = cyc;
        push_word(2'b01, 32'h03FF_FFFF, 1'b1);
        push_word(2'b01, 32'h0000_0001, 1'b1);
        drain(0, 50);
        repeat (3) step();
        check("t1_count", 32'(pulses0.size()), 32'd2);
        check("t1_lat0", 32'(pulses0[0]), 32'(n + 2));
        check("t1_lat1", 32'(pulses0[1]), 32'(n + 4));
        cpu_read(0, ADDR_DATA, rd);   check("t1_last", rd, 32'h1);
        cpu_read(0, ADDR_STATUS, rd); check("t1_status", rd, 32'h1);

        // Disabled overflow: 6 writes into DEPTH 4
        step();
        cpu_write(2'b01, ADDR_CTRL, 32'h0);
        for (int i = 0; i < 6; i++) push_word(2'b01, 32'h100 + 32'(i), i < 4);
        cpu_read(0, ADDR_STATUS, rd); check("t2_status", rd, 32'h406);
        cpu_read(0, ADDR_DROPS, rd);  check("t2_drops", rd, 32'd2);
        cpu_read(0, ADDR_DATA, rd);   check("t2_last", rd, 32'h103);
        step();
        pulses0.delete();
        cpu_write(2'b01, ADDR_CTRL, 32'h1);
        drain(0, 50);
        repeat (3) step();
        check("t2_count", 32'(pulses0.size()), 32'd4);
        cpu_write(2'b01, ADDR_CTRL, 32'h3);
        cpu_read(0, ADDR_STATUS, rd); check("t2_clr_status", rd, 32'h1);
        cpu_read(0, ADDR_CTRL, rd);   check("t2_ctrl_rb", rd, 32'h1);
        step();
        cpu_read(0, ADDR_DROPS, rd);  check("t2_clr_drops", rd, 32'd0);

        // Downstream full holds off launches
        step();
        fifo_full = 1'b1;
        pulses0.delete();
        push_word(2'b01, 32'h0AA, 1'b1);
        push_word(2'b01, 32'h0BB, 1'b1);
        repeat (20) step();
        check("t3_no_wr", 32'(pulses0.size()), 32'd0);
        cpu_read(0, ADDR_STATUS, rd); check("t3_status", rd, 32'h200);
        step();
        r = cyc;
        fifo_full = 1'b0;
        drain(0, 50);
        repeat (3) step();
        check("t3_count", 32'(pulses0.size()), 32'd2);
        check("t3_first", 32'(pulses0[0]), 32'(r + 1));

        // Gap spacing on the GAP_CYCLES=3 instance
        cpu_write(2'b10, ADDR_CTRL, 32'h1);
        pulses3.delete();
        push_word(2'b10, 32'h111, 1'b1);
        push_word(2'b10, 32'h222, 1'b1);
        push_word(2'b10, 32'h333, 1'b1);
        drain(1, 80);
        repeat (3) step();
        check("t4_count", 32'(pulses3.size()), 32'd3);
        check("t4_space0", 32'(pulses3[1] - pulses3[0]), 32'd5);
        check("t4_space1", 32'(pulses3[2] - pulses3[1]), 32'd5);

        // Push into a full queue coinciding with a pop
        fifo_full = 1'b1;
        pulses0.delete();
        for (int i = 0; i < 4; i++) push_word(2'b01, 32'h500 + 32'(i), 1'b1);
        cpu_read(0, ADDR_STATUS, rd); check("t5_full", rd, 32'h402);
        step();
        fifo_full = 1'b0;
        push_word(2'b01, 32'h504, 1'b1);
        cpu_read(0, ADDR_STATUS, rd); check("t5_status", rd, 32'h40A);
        cpu_read(0, ADDR_DROPS, rd);  check("t5_drops", rd, 32'd0);
        drain(0, 50);
        repeat (3) step();
        check("t5_count", 32'(pulses0.size()), 32'd5);

        // Clear while a word is in WRITE
        fifo_full = 1'b1;
        pulses0.delete();
        push_word(2'b01, 32'h600, 1'b1);
        for (int i = 1; i < 5; i++) push_word(2'b01, 32'h600 + 32'(i), 1'b0);
        cpu_read(0, ADDR_STATUS, rd); check("t6_pre_status", rd, 32'h406);
        cpu_read(0, ADDR_DROPS, rd);  check("t6_pre_drops", rd, 32'd1);
        step();
        fifo_full = 1'b0;
        step();
        check("t6_in_write", {31'd0, if0.fifo_wrreq}, 32'd1);
        cpu_write(2'b01, ADDR_CTRL, 32'h3);
        repeat (15) step();
        check("t6_count", 32'(pulses0.size()), 32'd1);
        cpu_read(0, ADDR_STATUS, rd); check("t6_status", rd, 32'h1);
        cpu_read(0, ADDR_DROPS, rd);  check("t6_drops", rd, 32'd0);

        // Asynchronous reset in the middle of GAP
        step();
        push_word(2'b10, 32'h2AB_CDEF, 1'b1);
        repeat (3) step();
        cpu_read(1, ADDR_STATUS, rd); check("t7_gap_status", rd, 32'h9);
        check("t7_pre_data", 32'(if3.fifo_data), 32'h2AB_CDEF);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t7_wrreq", {31'd0, if3.fifo_wrreq}, 32'd0);
        check("t7_data", 32'(if3.fifo_data), 32'd0);
        cpu_read(1, ADDR_DATA, rd);   check("t7_last", rd, 32'd0);
        cpu_read(1, ADDR_STATUS, rd); check("t7_status", rd, 32'h1);
        cpu_read(1, ADDR_CTRL, rd);   check("t7_ctrl", rd, 32'h0);
        check("t7_sb_empty", 32'(exp3.size()), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
